// File: rtl/noc_pkg.sv
// Shared mesh-switch definitions: flit type codes, VC states,
// output-port indices and header field offsets.
package noc_pkg;

  localparam logic [1:0] HEADER_ID = 2'b10;
  localparam logic [1:0] BODY_ID   = 2'b01;
  localparam logic [1:0] TAIL_ID   = 2'b11;

  localparam int OC_LOCAL = 0;
  localparam int OC_NORTH = 1;
  localparam int OC_EAST  = 2;
  localparam int OC_SOUTH = 3;
  localparam int OC_WEST  = 4;

  typedef enum logic [1:0] {
    VC_IDLE,
    VC_REQUESTING,
    VC_ACTIVE
  } vc_state_e;

  function automatic int row_lsb(input int flit_w, input int id_w,
                                 input int row_w);
    return flit_w - id_w - row_w;
  endfunction

  function automatic int col_lsb(input int flit_w, input int id_w,
                                 input int row_w, input int col_w);
    return flit_w - id_w - row_w - col_w;
  endfunction

endpackage

// File: rtl/circ_fifo.sv
// Circular-buffer FIFO with registered pointers and an occupancy count.
// The head entry is presented combinationally on rd_data.
module circ_fifo #(
  parameter int DW = 8,
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  output logic [DW-1:0] rd_data,
  output logic          full,
  output logic          empty
);

  logic [DW-1:0] mem [2**AW];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_wr;
  logic          do_rd;

  assign full    = (count == (AW+1)'(2**AW));
  assign empty   = (count == '0);
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_wr) - (AW+1)'(do_rd);
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the search starts at ptr; on advance the
// pointer moves to the slot after the winner.
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] win;
  int            idx;

  // Scan farthest-to-nearest so the last hit is the closest to ptr.
  always_comb begin
    grant = '0;
    win   = '0;
    idx   = 0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = (int'(ptr) + i) % N;
      if (req[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        win        = PW'(idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (advance && |req) begin
      ptr <= (int'(win) == N - 1) ? '0 : PW'(int'(win) + 1);
    end
  end

endmodule

// File: rtl/xy_router.sv
// Dimension-ordered XY route: resolve the column first, then the row.
// Larger column is east, larger row is south.
module xy_router
  import noc_pkg::*;
#(
  parameter int COL_CORD   = 1,
  parameter int ROW_CORD   = 1,
  parameter int COL_ADDR_W = 2,
  parameter int ROW_ADDR_W = 2,
  parameter int OUT_M      = 5
) (
  input  logic [ROW_ADDR_W-1:0] dst_row,
  input  logic [COL_ADDR_W-1:0] dst_col,
  output logic [OUT_M-1:0]      route
);

  logic go_e;
  logic go_w;
  logic go_s;
  logic go_n;

  always_comb begin
    go_e  = int'(dst_col) > COL_CORD;
    go_w  = int'(dst_col) < COL_CORD;
    go_s  = !go_e && !go_w && (int'(dst_row) > ROW_CORD);
    go_n  = !go_e && !go_w && (int'(dst_row) < ROW_CORD);
    route = '0;
    unique case (1'b1)
      go_e:    route[OC_EAST]  = 1'b1;
      go_w:    route[OC_WEST]  = 1'b1;
      go_s:    route[OC_SOUTH] = 1'b1;
      go_n:    route[OC_NORTH] = 1'b1;
      default: route[OC_LOCAL] = 1'b1;
    endcase
  end

endmodule

// File: rtl/vc_input_port.sv
// Multi-VC switch input port: per-VC buffer, route FSM and request,
// with a round-robin flit scheduler onto one crossbar input.
module vc_input_port
  import noc_pkg::*;
#(
  parameter int VC_NUM      = 2,
  parameter int VC_DEPTH_W  = 2,
  parameter int FLIT_DATA_W = 8,
  parameter int FLIT_ID_W   = 2,
  parameter int COL_CORD    = 1,
  parameter int ROW_CORD    = 1,
  parameter int COL_ADDR_W  = 2,
  parameter int ROW_ADDR_W  = 2,
  parameter int OUT_M       = 5,
  parameter int FLIT_W      = FLIT_DATA_W + FLIT_ID_W,
  parameter int VC_W        = $clog2(VC_NUM)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [FLIT_W-1:0]       data_i,
  input  logic [VC_W-1:0]         vc_id_i,
  input  logic                    wr_en_i,
  output logic [VC_NUM-1:0]       credit_o,
  output logic [VC_NUM*OUT_M-1:0] oc_req_o,
  input  logic [VC_NUM-1:0]       oc_granted_i,
  input  logic [OUT_M-1:0]        oc_rdy_i,
  output logic [FLIT_W-1:0]       oc_data_o,
  output logic [VC_W-1:0]         oc_vc_o,
  output logic [OUT_M-1:0]        oc_sel_o,
  output logic                    oc_data_vld_o,
  output logic [1:0]              err_o
);

  localparam int RL = row_lsb(FLIT_W, FLIT_ID_W, ROW_ADDR_W);
  localparam int CL = col_lsb(FLIT_W, FLIT_ID_W, ROW_ADDR_W, COL_ADDR_W);

  logic [FLIT_W-1:0]     head    [VC_NUM];
  logic [FLIT_ID_W-1:0]  head_id [VC_NUM];
  logic [ROW_ADDR_W-1:0] dst_row [VC_NUM];
  logic [COL_ADDR_W-1:0] dst_col [VC_NUM];
  logic [OUT_M-1:0]      route   [VC_NUM];
  vc_state_e             state_q [VC_NUM];
  vc_state_e             state_d [VC_NUM];

  logic [VC_NUM-1:0] full, empty, wr_sel, deq, drop;
  logic [VC_NUM-1:0] hdr_idle, elig, grant, hdr_act, tail_out;
  logic [FLIT_W-1:0] win_data;
  logic [VC_W-1:0]   win_vc;
  logic [OUT_M-1:0]  win_sel;

  for (genvar v = 0; v < VC_NUM; v++) begin : g_vc
    assign wr_sel[v]  = wr_en_i && (vc_id_i == VC_W'(v));
    assign head_id[v] = head[v][FLIT_W-1 -: FLIT_ID_W];
    assign oc_req_o[v*OUT_M +: OUT_M] =
      (state_q[v] == VC_REQUESTING) ? route[v] : '0;

    circ_fifo #(.DW(FLIT_W), .AW(VC_DEPTH_W)) u_fifo (
      .clk(clk_i), .rst(rst_i),
      .wr_en(wr_sel[v]), .wr_data(data_i),
      .rd_en(deq[v]), .rd_data(head[v]),
      .full(full[v]), .empty(empty[v])
    );

    xy_router #(
      .COL_CORD(COL_CORD), .ROW_CORD(ROW_CORD),
      .COL_ADDR_W(COL_ADDR_W), .ROW_ADDR_W(ROW_ADDR_W),
      .OUT_M(OUT_M)
    ) u_xy (
      .dst_row(dst_row[v]), .dst_col(dst_col[v]), .route(route[v])
    );
  end

  always_comb begin
    for (int v = 0; v < VC_NUM; v++) begin
      hdr_idle[v] = (state_q[v] == VC_IDLE) && !empty[v] &&
                    (head_id[v] == FLIT_ID_W'(HEADER_ID));
      drop[v]     = (state_q[v] == VC_IDLE) && !empty[v] &&
                    (head_id[v] != FLIT_ID_W'(HEADER_ID));
      elig[v]     = (state_q[v] == VC_ACTIVE) && !empty[v] &&
                    |(route[v] & oc_rdy_i);
    end
  end

  rr_arbiter #(.N(VC_NUM)) u_rr (
    .clk(clk_i), .rst(rst_i),
    .req(elig), .advance(|elig), .grant(grant)
  );

  assign deq      = drop | grant;
  assign credit_o = deq;

  always_comb begin
    for (int v = 0; v < VC_NUM; v++) begin
      hdr_act[v]  = grant[v] && (head_id[v] == FLIT_ID_W'(HEADER_ID));
      tail_out[v] = grant[v] && (head_id[v] == FLIT_ID_W'(TAIL_ID));
      state_d[v]  = state_q[v];
      unique case (state_q[v])
        VC_IDLE:
          if (hdr_idle[v]) state_d[v] = VC_REQUESTING;
        VC_REQUESTING:
          if (oc_granted_i[v]) state_d[v] = VC_ACTIVE;
        VC_ACTIVE:
          if (tail_out[v]) state_d[v] = VC_IDLE;
        default: state_d[v] = VC_IDLE;
      endcase
    end
  end

  always_comb begin
    win_data = '0;
    win_vc   = '0;
    win_sel  = '0;
    for (int v = 0; v < VC_NUM; v++) begin
      if (grant[v]) begin
        win_data = head[v];
        win_vc   = VC_W'(v);
        win_sel  = route[v];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int v = 0; v < VC_NUM; v++) begin
        state_q[v] <= VC_IDLE;
        dst_row[v] <= '0;
        dst_col[v] <= '0;
      end
    end else begin
      for (int v = 0; v < VC_NUM; v++) begin
        state_q[v] <= state_d[v];
        if (hdr_idle[v]) begin
          dst_row[v] <= head[v][RL +: ROW_ADDR_W];
          dst_col[v] <= head[v][CL +: COL_ADDR_W];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      oc_data_vld_o <= 1'b0;
      oc_data_o     <= '0;
      oc_vc_o       <= '0;
      oc_sel_o      <= '0;
      err_o         <= '0;
    end else begin
      oc_data_vld_o <= |grant;
      oc_data_o     <= win_data;
      oc_vc_o       <= win_vc;
      oc_sel_o      <= win_sel;
      err_o         <= err_o | {|(drop | hdr_act), wr_en_i && full[vc_id_i]};
    end
  end

endmodule

// File: tb/tb_vc_input_port.sv
// Directed bench for vc_input_port with a per-VC output scoreboard.
module tb_vc_input_port;

  localparam logic [4:0] L = 5'b00001;
  localparam logic [4:0] N = 5'b00010;
  localparam logic [4:0] E = 5'b00100;
  localparam logic [4:0] S = 5'b01000;
  localparam logic [4:0] W = 5'b10000;

  logic       clk = 1'b0;
  logic       rst_i;
  logic [9:0] data_i;
  logic       vc_id_i;
  logic       wr_en_i;
  logic [1:0] credit_o;
  logic [9:0] oc_req_o;
  logic [1:0] oc_granted_i;
  logic [4:0] oc_rdy_i;
  logic [9:0] oc_data_o;
  logic       oc_vc_o;
  logic [4:0] oc_sel_o;
  logic       oc_data_vld_o;
  logic [1:0] err_o;

  int n_cmp = 0;
  int n_bad = 0;
  int cred0 = 0;
  int cred1 = 0;

  logic [14:0] q0 [$];
  logic [14:0] q1 [$];
  logic        vc_seq [$];
  logic [14:0] exp_f;
  bit          have;

  vc_input_port dut (
    .clk_i(clk), .rst_i(rst_i), .data_i(data_i), .vc_id_i(vc_id_i),
    .wr_en_i(wr_en_i), .credit_o(credit_o), .oc_req_o(oc_req_o),
    .oc_granted_i(oc_granted_i), .oc_rdy_i(oc_rdy_i),
    .oc_data_o(oc_data_o), .oc_vc_o(oc_vc_o), .oc_sel_o(oc_sel_o),
    .oc_data_vld_o(oc_data_vld_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [9:0] hdr(input logic [1:0] r, input logic [1:0] c,
                                     input logic [3:0] p);
    return {2'b10, r, c, p};
  endfunction

  function automatic logic [9:0] body(input logic [7:0] p);
    return {2'b01, p};
  endfunction

  function automatic logic [9:0] tail(input logic [7:0] p);
    return {2'b11, p};
  endfunction

  // Output monitor: scoreboard pop and credit tally.
  always @(negedge clk) begin
    if (credit_o[0]) cred0++;
    if (credit_o[1]) cred1++;
    if (oc_data_vld_o) begin
      vc_seq.push_back(oc_vc_o);
      have  = 1'b0;
      exp_f = '0;
      if (!oc_vc_o && q0.size() > 0) begin
        exp_f = q0.pop_front();
        have  = 1'b1;
      end else if (oc_vc_o && q1.size() > 0) begin
        exp_f = q1.pop_front();
        have  = 1'b1;
      end
      n_cmp++;
      assert (have) else begin
        n_bad++;
        $error("FAIL unexpected_flit: observed vc %0d data %0h expected none",
               oc_vc_o, oc_data_o);
      end
      if (have) begin
        n_cmp++;
        assert ({oc_sel_o, oc_data_o} === exp_f) else begin
          n_bad++;
          $error("FAIL flit_vc%0d: observed %0h expected %0h",
                 oc_vc_o, {oc_sel_o, oc_data_o}, exp_f);
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int v, input logic [9:0] f,
                      input logic [4:0] sel, input bit expect_out);
    tick();
    wr_en_i = 1'b1;
    vc_id_i = v[0];
    data_i  = f;
    if (expect_out) begin
      if (v == 0) q0.push_back({sel, f});
      else        q1.push_back({sel, f});
    end
  endtask

  task automatic idle();
    tick();
    wr_en_i = 1'b0;
    data_i  = '0;
  endtask

  task automatic grant(input logic [1:0] g);
    tick();
    oc_granted_i = g;
    tick();
    oc_granted_i = '0;
  endtask

  task automatic wait_req(input int v, input int bound,
                          output logic [4:0] r);
    r = '0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      r = oc_req_o[v*5 +: 5];
      if (r != '0) break;
    end
  endtask

  task automatic observe(input int cycles, output int nvld, output int run);
    int cur;
    nvld = 0;
    run  = 0;
    cur  = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (oc_data_vld_o) begin
        nvld++;
        cur++;
        if (cur > run) run = cur;
      end else begin
        cur = 0;
      end
    end
  endtask

  task automatic wait_drain(input int bound);
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (q0.size() == 0 && q1.size() == 0) break;
    end
    check("drain_empty", q0.size() + q1.size(), 0);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_credit"}, credit_o, 0);
    check({tag, "_req"}, oc_req_o, 0);
    check({tag, "_vld"}, oc_data_vld_o, 0);
    check({tag, "_data"}, oc_data_o, 0);
    check({tag, "_vc"}, oc_vc_o, 0);
    check({tag, "_sel"}, oc_sel_o, 0);
    check({tag, "_err"}, err_o, 0);
  endtask

  initial begin
    logic [4:0] r;
    int nv;
    int run;
    rst_i        = 1'b1;
    data_i       = '0;
    vc_id_i      = 1'b0;
    wr_en_i      = 1'b0;
    oc_granted_i = '0;
    oc_rdy_i     = '1;
    tick();
    tick();
    @(negedge clk);
    check_quiet("reset");
    tick();
    rst_i = 1'b0;

    // Single packet on VC0, route east.
    cred0 = 0;
    cred1 = 0;
    send(0, hdr(2'd1, 2'd2, 4'h1), E, 1);
    send(0, body(8'h11), E, 1);
    send(0, body(8'h12), E, 1);
    send(0, tail(8'h13), E, 1);
    idle();
    wait_req(0, 10, r);
    check("p1_req_east", r, E);
    check("p1_req_vc1_zero", oc_req_o[9:5], 0);
    grant(2'b01);
    observe(8, nv, run);
    check("p1_nvld", nv, 4);
    check("p1_back_to_back", run, 4);
    check("p1_credit0", cred0, 4);
    check("p1_credit1", cred1, 0);
    check("p1_idle_no_req", oc_req_o, 0);

    // Interleave VC0 (east) and VC1 (south); pointer was left at 1.
    vc_seq.delete();
    send(0, hdr(2'd1, 2'd3, 4'h2), E, 1);
    send(1, hdr(2'd2, 2'd1, 4'h3), S, 1);
    send(0, body(8'h21), E, 1);
    send(1, body(8'h31), S, 1);
    send(0, body(8'h22), E, 1);
    send(1, body(8'h32), S, 1);
    send(0, tail(8'h23), E, 1);
    send(1, tail(8'h33), S, 1);
    idle();
    wait_req(0, 10, r);
    check("il_req0", r, E);
    wait_req(1, 10, r);
    check("il_req1_south", r, S);
    grant(2'b11);
    observe(12, nv, run);
    check("il_nvld", nv, 8);
    check("il_back_to_back", run, 8);
    check("il_seq_len", vc_seq.size(), 8);
    for (int i = 0; i < vc_seq.size(); i++)
      check($sformatf("il_vc_%0d", i), vc_seq[i], (i % 2 == 0) ? 1 : 0);

    // Backpressure on VC0's east output for three cycles.
    send(0, hdr(2'd0, 2'd3, 4'h4), E, 1);
    send(1, hdr(2'd3, 2'd1, 4'h5), S, 1);
    send(0, body(8'h41), E, 1);
    send(1, body(8'h51), S, 1);
    send(0, body(8'h42), E, 1);
    send(1, body(8'h52), S, 1);
    send(0, tail(8'h43), E, 1);
    send(1, tail(8'h53), S, 1);
    idle();
    wait_req(0, 10, r);
    check("bp_req0", r, E);
    wait_req(1, 10, r);
    check("bp_req1", r, S);
    oc_rdy_i = 5'b11011;
    tick();
    oc_granted_i = 2'b11;
    cred0 = 0;
    cred1 = 0;
    tick();
    oc_granted_i = '0;
    tick();
    tick();
    tick();
    check("bp_vc0_stalled", cred0, 0);
    check("bp_vc1_streams", cred1, 3);
    oc_rdy_i = '1;
    wait_drain(30);
    check("bp_credit0_total", cred0, 4);
    check("bp_credit1_total", cred1, 4);

    // Overflow of VC1 while it waits for a grant.
    cred1 = 0;
    send(1, hdr(2'd2, 2'd1, 4'h6), S, 1);
    send(1, body(8'h61), S, 1);
    send(1, body(8'h62), S, 1);
    send(1, body(8'h63), S, 1);
    idle();
    @(negedge clk);
    check("ovf_err_before", err_o[0], 0);
    send(1, body(8'h6f), S, 0);
    idle();
    @(negedge clk);
    check("ovf_err_set", err_o[0], 1);
    repeat (3) @(negedge clk);
    check("ovf_err_sticky", err_o[0], 1);
    check("ovf_no_credit", cred1, 0);
    wait_req(1, 10, r);
    check("ovf_req1", r, S);
    grant(2'b10);
    send(1, tail(8'h64), S, 1);
    idle();
    wait_drain(30);
    check("ovf_credits", cred1, 5);

    // Body flit at an idle VC is dropped with a credit.
    cred0 = 0;
    send(0, body(8'h77), E, 0);
    idle();
    repeat (3) @(negedge clk);
    check("idle_body_credit", cred0, 1);
    check("idle_body_err", err_o[1], 1);
    check("idle_body_no_req", oc_req_o, 0);

    // Reset with three flits buffered in VC0.
    send(0, hdr(2'd1, 2'd0, 4'h8), W, 0);
    send(0, body(8'h81), W, 0);
    send(0, body(8'h82), W, 0);
    idle();
    @(negedge clk);
    check("rst_pre_req_west", oc_req_o[4:0], W);
    tick();
    rst_i = 1'b1;
    cred0 = 0;
    tick();
    rst_i = 1'b0;
    @(negedge clk);
    check_quiet("rst_mid");
    repeat (5) @(negedge clk);
    check("rst_no_credit", cred0, 0);
    check("rst_flushed", oc_req_o, 0);

    // Header inside an active packet is forwarded and flagged.
    cred0 = 0;
    send(0, hdr(2'd1, 2'd2, 4'h9), E, 1);
    send(0, body(8'h91), E, 1);
    send(0, hdr(2'd1, 2'd2, 4'ha), E, 1);
    send(0, tail(8'h93), E, 1);
    idle();
    wait_req(0, 10, r);
    check("mh_req0", r, E);
    check("mh_err_clear", err_o, 0);
    grant(2'b01);
    wait_drain(30);
    check("mh_err_set", err_o, 2'b10);
    check("mh_credits", cred0, 4);

    // Fresh packet to the local port on VC1.
    cred1 = 0;
    send(1, hdr(2'd1, 2'd1, 4'hb), L, 1);
    send(1, body(8'hb1), L, 1);
    send(1, tail(8'hb2), L, 1);
    idle();
    wait_req(1, 10, r);
    check("fr_req_local", r, L);
    grant(2'b10);
    wait_drain(30);
    check("fr_credits", cred1, 3);
    repeat (3) @(negedge clk);
    check("end_no_req", oc_req_o, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
